// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
// The CHK state is only reachable when CHECKSUM_EN is defined.
package imem_loader_pkg;

    localparam int HDR_BYTES      = 2;
    localparam int BYTES_PER_WORD = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR_HI,
        S_HDR_LO,
        S_DATA,
        S_WRITE,
        S_DONE,
        S_ERR,
        S_CHK
    } state_t;

    // States in which the loader offers byte_ready.
    function automatic logic takes_bytes(input state_t s);
        return (s == S_HDR_HI) || (s == S_HDR_LO) ||
               (s == S_DATA)   || (s == S_CHK);
    endfunction

endpackage

// File: rtl/imem_loader_byte_packer.sv
// byte_packer: MSB-first byte-to-word shift accumulator.
// word_ready pulses the cycle after the last byte of a word lands.
module byte_packer
    import imem_loader_pkg::*;
#(
    parameter int WORD_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_clear,
    input  logic              i_push,
    input  logic [7:0]        i_byte,
    output logic [WORD_W-1:0] o_word,
    output logic              o_last,
    output logic              o_word_ready
);

    localparam int CNT_W = $clog2(BYTES_PER_WORD);

    logic [CNT_W-1:0]  r_cnt;
    logic [WORD_W-1:0] r_acc;
    logic              r_word_ready;

    assign o_last       = i_push && (r_cnt == CNT_W'(BYTES_PER_WORD - 1));
    assign o_word       = r_acc;
    assign o_word_ready = r_word_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt        <= '0;
            r_acc        <= '0;
            r_word_ready <= 1'b0;
        end else begin
            r_word_ready <= o_last;
            if (i_clear) begin
                r_cnt <= '0;
            end else if (i_push) begin
                r_acc <= {r_acc[WORD_W-9:0], i_byte};
                r_cnt <= o_last ? '0 : r_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/imem_loader.sv
// imem_loader: streams a length-prefixed image into instruction memory
// and holds the CPU in reset until it is complete. Option: CHECKSUM_EN.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int WORD_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [WORD_W-1:0] imem_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              error
);

    localparam logic [16:0] DEPTH = 17'd1 << ADDR_W;

`ifdef CHECKSUM_EN
    localparam state_t S_END = S_CHK;
`else
    localparam state_t S_END = S_DONE;
`endif

    state_t          r_state;
    state_t          w_next;
    logic            r_byte_ready;
    logic            r_hold;
    logic            r_done;
    logic            r_err;
    logic [15:0]     r_n;
    logic [ADDR_W:0] r_widx;
    logic [ADDR_W:0] w_widx_inc;
    logic [7:0]      r_csum;
    logic [15:0]     w_hdr_n;
    logic            w_xfer;
    logic            w_push;
    logic            w_pack_last;

    assign w_xfer     = byte_valid & r_byte_ready;
    assign w_push     = w_xfer && (r_state == S_DATA);
    assign w_hdr_n    = {r_n[15:8], byte_data};
    assign w_widx_inc = r_widx + 1'b1;

    byte_packer #(.WORD_W(WORD_W)) u_packer (
        .clk          (clk),
        .reset        (reset),
        .i_clear      (r_state != S_DATA),
        .i_push       (w_push),
        .i_byte       (byte_data),
        .o_word       (imem_wdata),
        .o_last       (w_pack_last),
        .o_word_ready (imem_we)
    );

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:   if (start) w_next = S_HDR_HI;
            S_HDR_HI: if (w_xfer) w_next = S_HDR_LO;
            S_HDR_LO: begin
                if (w_xfer) begin
                    if (w_hdr_n == 16'd0)
                        w_next = S_END;
                    else if ({1'b0, w_hdr_n} > DEPTH)
                        w_next = S_ERR;
                    else
                        w_next = S_DATA;
                end
            end
            S_DATA:   if (w_pack_last) w_next = S_WRITE;
            S_WRITE: begin
                if (17'(w_widx_inc) == {1'b0, r_n})
                    w_next = S_END;
                else
                    w_next = S_DATA;
            end
            S_DONE,
            S_ERR:    if (start) w_next = S_HDR_HI;
            S_CHK: begin
                if (w_xfer)
                    w_next = (byte_data == r_csum) ? S_DONE : S_ERR;
            end
            default:  w_next = S_IDLE;
        endcase
    end

    // Outputs are registered decodes of the next state.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_byte_ready <= 1'b0;
            r_hold       <= 1'b1;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
            r_n          <= '0;
            r_widx       <= '0;
            r_csum       <= '0;
        end else begin
            r_state      <= w_next;
            r_byte_ready <= takes_bytes(w_next);
            r_hold       <= (w_next != S_DONE);
            r_done       <= (w_next == S_DONE);
            r_err        <= (w_next == S_ERR);
            if (r_state == S_HDR_HI && w_xfer)
                r_n[15:8] <= byte_data;
            if (r_state == S_HDR_LO && w_xfer) begin
                r_n[7:0] <= byte_data;
                r_widx   <= '0;
                r_csum   <= '0;
            end
            if (w_push)
                r_csum <= r_csum ^ byte_data;
            if (r_state == S_WRITE)
                r_widx <= w_widx_inc;
        end
    end

    assign byte_ready = r_byte_ready;
    assign imem_addr  = r_widx[ADDR_W-1:0];
    assign cpu_hold   = r_hold;
    assign done       = r_done;
    assign error      = r_err;

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
Writer side of the instruction-memory interface that the fetch stage reads from. It accepts a byte stream over a valid/ready handshake and assembles big-endian 32-bit instruction words. It writes those words into instruction memory at sequential addresses from 0. While it loads, it holds the pipeline in reset through cpu_hold, and it releases the pipeline once the image is complete.

Parameters:
ADDR_W, 8, instruction-memory word-address width; depth = 2**ADDR_W words
WORD_W, 32, instruction word width; fixed at 32 (4 bytes per word)

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
start  input  1  begin a load; sampled only in IDLE, DONE and ERR
byte_valid  input  1  byte_data is valid this cycle
byte_data  input  8  stream byte
byte_ready  output  1  loader accepts the byte this cycle; transfer = byte_valid & byte_ready
imem_we  output  1  instruction-memory write strobe, one-cycle pulse
imem_addr  output  ADDR_W  word address of the write
imem_wdata  output  32  instruction word to write
cpu_hold  output  1  drives the pipeline reset; high except in DONE
done  output  1  image fully written
error  output  1  header word count exceeds depth (or checksum fail, see below)

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- Reset values: state=IDLE, byte_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, cpu_hold=1, done=0, error=0. Word counter, byte counter and accumulators are all 0.
- Stream format: 2 header bytes give the 16-bit word count N, MSB first. Then N×4 payload bytes follow; each word is sent MSB byte first.
- States: IDLE, HDR_HI, HDR_LO, DATA, WRITE, DONE, ERR.
- IDLE:
  - byte_ready=0.
  - start=1 -> HDR_HI next cycle.
- HDR_HI:
  - byte_ready=1.
  - On transfer, latch count[15:8] -> HDR_LO.
- HDR_LO:
  - byte_ready=1.
  - On transfer, latch count[7:0] and evaluate the full 16-bit N.
  - N=0 -> DONE.
  - N > 2**ADDR_W -> ERR.
  - Otherwise -> DATA, with word index=0 and byte index=0.
- DATA:
  - byte_ready=1.
  - Each transfer shifts the byte into the accumulator (acc = {acc[23:0], byte}) and increments the byte index.
  - On the 4th byte -> WRITE.
  - byte_valid low: hold state, no change.
- WRITE (exactly 1 cycle):
  - byte_ready=0, imem_we=1, imem_addr=word index, imem_wdata=acc.
  - The write occurs 1 cycle after the 4th byte is accepted.
  - Afterwards, word index increments. If the new index equals N -> DONE, otherwise -> DATA.
- DONE:
  - done=1, cpu_hold=0, byte_ready=0.
  - start=1 -> HDR_HI; done drops and cpu_hold rises on the next cycle.
- ERR:
  - error=1, cpu_hold=1, byte_ready=0.
  - Only start or reset exits; start -> HDR_HI and clears error.
- start is ignored in HDR_HI, HDR_LO, DATA and WRITE.
- Boundary cases:
  - N = 2**ADDR_W is legal. The last write goes to address 2**ADDR_W-1, and the word index uses ADDR_W+1 bits, so it does not wrap.
  - Reset mid-load: back to IDLE next cycle. A partially assembled word is discarded and never written. Words already written stay in memory.
  - Byte accepted on the cycle a state is entered: a transfer is defined only by byte_ready in the current cycle. byte_ready is a registered decode of state, so it needs no combinational path from byte_valid.
- Throughput: 1 word per 5 cycles at full byte rate.

Optional Feature:
CHECKSUM_EN
- With CHECKSUM_EN defined:
  - After the last payload word, a state CHK accepts one extra byte (byte_ready=1) that equals the XOR of all payload bytes.
  - Match -> DONE; mismatch -> ERR with error=1.
  - For N=0, the checksum byte is still required and must be 0x00.
- Without CHECKSUM_EN: no CHK state; the stream ends after the last payload byte.

Decomposition:
- Shared package imem_loader_pkg holds:
  - the state enum encoding;
  - HDR_BYTES=2;
  - BYTES_PER_WORD=4.
- One natural sub-module, byte_packer: a 4-byte shift accumulator with its byte counter and a word_ready flag, reused by any future byte-to-word loader.
- The FSM and counters stay in imem_loader.

Test Plan:
- Reset, then start, then N=2 (bytes 00 02) and payload E3A00001 E2800001 at full rate -> two we pulses: addr0=E3A00001, addr1=E2800001. done=1 and cpu_hold=0 one cycle after the 2nd write.
- Same image with byte_valid toggling every other cycle -> identical writes and data. No byte is lost or duplicated, and a byte is taken only while byte_ready=1.
- Header 00 00 -> DONE directly with no imem_we. With CHECKSUM_EN, checksum byte 00 is required first.
- ADDR_W=8 with header 01 01 (257) -> ERR, error=1, cpu_hold=1, no writes. start then loads a valid N=1 image and error clears.
- reset asserted after 2 payload bytes of word 1 -> IDLE next cycle, no imem_we for the partial word, all outputs at reset values.
- CHECKSUM_EN with N=1 and word 01020304: checksum 04 -> DONE; checksum 05 -> ERR.
